// File: rtl/banco_registros_mp_pkg.sv
// Shared definitions for the banco_registros_mp register file slice.
// Optional build macro: REGFILE_BYPASS_EN (write-to-read bypass).
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;

    // Clear-sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    // Address width for a bank of n registers (at least one bit)
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/banco_registros_mp_clear_fsm.sv
// Sequential clear controller: walks every clearable register index once,
// one per cycle, and reports busy/done from registered state.
// Optional build macro: REGFILE_BYPASS_EN (not used in this file).
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS    = NREGS_DEFAULT,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned AW       = addr_width(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] FIRST_IDX = ZERO_REG ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state, index and registered-output decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    idx_d   = FIRST_IDX;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + AW'(1);
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index and handshake registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy = busy_q;
    assign clr_done = done_q;
    assign clr_we   = (state_q == SWEEP);
    assign clr_idx  = idx_q;

endmodule

// File: rtl/banco_registros_mp.sv
// Multi-port integer register file: NRD combinational reads, NWR
// prioritised synchronous writes, optional hardwired-zero x0 and a
// sequential clear sweep.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding.
module banco_registros_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN     = XLEN_DEFAULT,
    parameter  int unsigned NREGS    = NREGS_DEFAULT,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned NWR      = 1,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned AW       = addr_width(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic                 clr_done
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            clr_we;
    logic [AW-1:0]   clr_idx;

    regfile_clear_fsm #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // Write arbitration: sweep owns the array; otherwise later ports override earlier ones
    always_comb begin
        logic [AW-1:0] wa;
        wa = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (clr_we) begin
            regs_d[clr_idx] = '0;
        end else begin
            for (int unsigned p = 0; p < NWR; p++) begin
                wa = wr_addr[p*AW +: AW];
                if (wr_en[p] && !(ZERO_REG && (wa == '0))) begin
                    regs_d[wa] = wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Storage array, cleared asynchronously on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;
        ra      = '0;
        rv      = '0;
        rd_data = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            rv = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
            // Ascending scan so the highest-priority matching port is the last to assign
            if (!clr_we) begin
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (wr_en[p] && (wr_addr[p*AW +: AW] == ra)) begin
                        rv = wr_data[p*XLEN +: XLEN];
                    end
                end
            end
`endif
            if (ZERO_REG && (ra == '0)) begin
                rv = '0;
            end
            rd_data[i*XLEN +: XLEN] = rv;
        end
    end

endmodule

// File: tb/tb_banco_registros_mp.sv
// Self-checking bench for banco_registros_mp (NRD=2, NWR=2, defaults otherwise).
// Honours REGFILE_BYPASS_EN when the build defines it.
module tb_banco_registros_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic              clk;
    logic              reset;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference contents and whether the bench expects a sweep to own the array
    logic [31:0] mdl [NREGS];
    bit          in_sweep = 1'b0;

    banco_registros_mp #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (2),
        .NWR      (2),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] wa(input int p);
        return (p == 0) ? wr_addr[4:0] : wr_addr[9:5];
    endfunction

    function automatic logic [31:0] wd(input int p);
        return (p == 0) ? wr_data[31:0] : wr_data[63:32];
    endfunction

    // What a read of address a should return right now
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = mdl[a];
`ifdef REGFILE_BYPASS_EN
        if (!in_sweep) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wa(p) == a) v = wd(p);
            end
        end
`endif
        return v;
    endfunction

    // Advance one clock edge, committing the pending external writes to the model
    task automatic tick();
        if (!in_sweep && reset) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wa(p) != 5'd0) mdl[wa(p)] = wd(p);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        if (p == 0) begin
            wr_addr[4:0]  = a;
            wr_data[31:0] = d;
        end else begin
            wr_addr[9:5]   = a;
            wr_data[63:32] = d;
        end
    endtask

    task automatic check_reads(input string tag, input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
        check({tag, "_p0"}, rd_data[31:0],  exp_read(a0));
        check({tag, "_p1"}, rd_data[63:32], exp_read(a1));
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < NREGS; a += 2) begin
            check_reads(tag, 5'(a), 5'(a + 1));
        end
    endtask

    task automatic fill_random();
        for (int a = 1; a < NREGS; a += 2) begin
            set_wr(0, 5'(a), $urandom | 32'h1);
            set_wr(1, 5'(a + 1), $urandom | 32'h1);
            tick();
        end
        wr_en = 2'b00;
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) mdl[r] = 32'h0;
        reset   = 1'b1;
        rd_addr = '0;
        wr_en   = 2'b00;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        #1 reset = 1'b0;
        #5;

        // Reset state
        check("rst_busy", 32'(clr_busy), 32'h0);
        check("rst_done", 32'(clr_done), 32'h0);
        check_all("rst_read");
        @(posedge clk);
        #20 reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic write/read and hardwired zero
        set_wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        wr_en = 2'b00;
        check_reads("x5", 5'd5, 5'd5);
        check("x5_val", rd_data[31:0], 32'hDEADBEEF);
        set_wr(0, 5'd0, 32'h1234);
        tick();
        wr_en = 2'b00;
        check_reads("x0", 5'd0, 5'd0);
        check("x0_val", rd_data[63:32], 32'h0);

        // Same-address conflict: port 1 wins
        set_wr(0, 5'd7, 32'h1111);
        set_wr(1, 5'd7, 32'h2222);
        tick();
        wr_en = 2'b00;
        check_reads("x7", 5'd7, 5'd6);
        check("x7_val", rd_data[31:0], 32'h2222);

        // Same-cycle write and read of x9
        set_wr(0, 5'd9, 32'h00000077);
        tick();
        set_wr(1, 5'd9, 32'hA5A5A5A5);
        wr_en[0] = 1'b0;
        check_reads("x9_same", 5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
        check("x9_same_val", rd_data[31:0], 32'hA5A5A5A5);
`else
        check("x9_same_val", rd_data[31:0], 32'h00000077);
`endif
        tick();
        wr_en = 2'b00;
        check_reads("x9_next", 5'd9, 5'd9);
        check("x9_next_val", rd_data[31:0], 32'hA5A5A5A5);

        // Randomised dual-port traffic against the model
        for (int c = 0; c < 60; c++) begin
            wr_en   = 2'($urandom);
            wr_addr = 10'($urandom);
            wr_data = {$urandom, $urandom};
            if (c % 7 == 0) wr_addr[9:5] = wr_addr[4:0];
            check_reads("rand", 5'($urandom), (c % 5 == 0) ? wr_addr[9:5] : 5'($urandom));
            tick();
        end
        wr_en = 2'b00;
        check_all("rand_final");

        // Full sweep with a mid-sweep write attempt
        fill_random();
        check_all("filled");
        clr_req = 1'b1;
        tick();
        clr_req  = 1'b0;
        in_sweep = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            check("sweep_busy", 32'(clr_busy), 32'h1);
            check("sweep_done", 32'(clr_done), 32'h0);
            if (n == 11) check_reads("sweep_part", 5'd10, 5'd25);
            if (n == 10) begin
                set_wr(0, 5'd3, 32'hCAFEF00D);
                set_wr(1, 5'd25, 32'hBADC0DE5);
            end
            tick();
            mdl[n] = 32'h0;
            wr_en  = 2'b00;
        end
        in_sweep = 1'b0;
        check("sweep_end_busy", 32'(clr_busy), 32'h0);
        check("sweep_end_done", 32'(clr_done), 32'h1);
        tick();
        check("post_busy", 32'(clr_busy), 32'h0);
        check("post_done", 32'(clr_done), 32'h0);
        check_all("swept");

        // Write accepted while the controller reports done
        fill_random();
        clr_req = 1'b1;
        tick();
        clr_req  = 1'b0;
        in_sweep = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            tick();
            mdl[n] = 32'h0;
        end
        in_sweep = 1'b0;
        check("done2", 32'(clr_done), 32'h1);
        set_wr(0, 5'd12, 32'h5A5A0012);
        tick();
        wr_en = 2'b00;
        check_reads("done_wr", 5'd12, 5'd13);

        // Reset in the middle of a sweep
        fill_random();
        clr_req = 1'b1;
        tick();
        clr_req  = 1'b0;
        in_sweep = 1'b1;
        for (int n = 1; n < 10; n++) begin
            tick();
            mdl[n] = 32'h0;
        end
        reset = 1'b0;
        in_sweep = 1'b0;
        for (int r = 0; r < NREGS; r++) mdl[r] = 32'h0;
        #1;
        check("abort_busy", 32'(clr_busy), 32'h0);
        check("abort_done", 32'(clr_done), 32'h0);
        check_all("abort_read");
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_hold_done", 32'(clr_done), 32'h0);
        end
        #20 reset = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            check("idle_busy", 32'(clr_busy), 32'h0);
            check("idle_done", 32'(clr_done), 32'h0);
            tick();
        end
        set_wr(1, 5'd4, 32'h0BADF00D);
        tick();
        wr_en = 2'b00;
        check_reads("idle_wr", 5'd4, 5'd5);

        // Held request: one done pulse, back to idle, then a fresh sweep
        clr_req = 1'b1;
        tick();
        in_sweep = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            tick();
            mdl[n] = 32'h0;
        end
        in_sweep = 1'b0;
        check("held_done", 32'(clr_done), 32'h1);
        check("held_done_busy", 32'(clr_busy), 32'h0);
        tick();
        check("held_idle_busy", 32'(clr_busy), 32'h0);
        check("held_idle_done", 32'(clr_done), 32'h0);
        tick();
        check("held_restart", 32'(clr_busy), 32'h1);
        clr_req  = 1'b0;
        in_sweep = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            tick();
        end
        in_sweep = 1'b0;
        check("held_done2", 32'(clr_done), 32'h1);
        tick();
        check("held_final_done", 32'(clr_done), 32'h0);
        check_all("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
